// File: rtl/fibonacci_multi.sv
// Fibonacci generator presenting LANES consecutive terms per group, one group per cycle, valid/ready out.
// Optional macro FIB_OVERFLOW_HALT_EN: stop in DONE instead of presenting a group holding an overflowed term.
`timescale 1ns/1ps

module fibonacci_multi #(
   parameter int W     = 16,
   parameter int LANES = 2,
   parameter int CW    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [W-1:0]         seed0,
   input  logic [W-1:0]         seed1,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [LANES*W-1:0]   num,
   output logic                 overflow,
   output logic [CW-1:0]        count
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [W-1:0]              r_x;
   logic [W-1:0]              r_y;
   logic [LANES*W-1:0]        r_num;
   logic [CW-1:0]             r_count;
   logic [LANES+1:0][W-1:0]   w_c;
   logic                      w_adv;
   logic                      w_halt;

   // r_x/r_y hold the first two terms of the next group; a start swaps in the seeds instead.
   assign w_adv = (r_state == RUN) && out_ready;

`ifdef FIB_OVERFLOW_HALT_EN
   logic                      r_ox;
   logic                      r_oy;
   logic                      r_overflow;
   logic [LANES+1:0]          w_o;

   always_comb begin
      logic [LANES+1:0][W-1:0] v_c;
      logic [LANES+1:0]        v_o;
      v_c    = '0;
      v_o    = '0;
      v_c[0] = start ? seed0 : r_x;
      v_c[1] = start ? seed1 : r_y;
      v_o[0] = start ? 1'b0 : r_ox;
      v_o[1] = start ? 1'b0 : r_oy;
      for (int k = 2; k < LANES + 2; k++) begin
         {v_o[k], v_c[k]} = {1'b0, v_c[k-1]} + {1'b0, v_c[k-2]};
      end
      w_c = v_c;
      w_o = v_o;
   end

   assign w_halt = |w_o[LANES-1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ox       <= 1'b0;
         r_oy       <= 1'b0;
         r_overflow <= 1'b0;
      end else if (start || w_adv) begin
         r_overflow <= w_halt;
         if (!w_halt) begin
            r_ox <= w_o[LANES];
            r_oy <= w_o[LANES+1];
         end
      end
   end

   assign overflow = r_overflow;
`else
   always_comb begin
      logic [LANES+1:0][W-1:0] v_c;
      v_c    = '0;
      v_c[0] = start ? seed0 : r_x;
      v_c[1] = start ? seed1 : r_y;
      for (int k = 2; k < LANES + 2; k++) begin
         v_c[k] = v_c[k-1] + v_c[k-2];
      end
      w_c = v_c;
   end

   assign w_halt   = 1'b0;
   assign overflow = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // start wins over a concurrent handshake and restarts from any state
   always_comb begin
      w_state_nxt = r_state;
      if (start) begin
         w_state_nxt = w_halt ? DONE : RUN;
      end else if (w_adv && w_halt) begin
         w_state_nxt = DONE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_x     <= '0;
         r_y     <= '0;
         r_num   <= '0;
         r_count <= '0;
      end else if (start || w_adv) begin
         r_count <= start ? '0 : r_count + 1'b1;
         if (!w_halt) begin
            r_num <= w_c[LANES-1:0];
            r_x   <= w_c[LANES];
            r_y   <= w_c[LANES+1];
         end
      end
   end

   assign out_valid = (r_state == RUN);
   assign num       = r_num;
   assign count     = r_count;

endmodule

// File: tb/tb_fibonacci_multi.sv
// Bench for fibonacci_multi: LANES=2 and LANES=4 instances share stimulus and are checked every cycle
// against a term-index model; honours FIB_OVERFLOW_HALT_EN if defined.
`timescale 1ns/1ps

module tb_fibonacci_multi;

`ifdef FIB_OVERFLOW_HALT_EN
   localparam bit HALT = 1'b1;
`else
   localparam bit HALT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        out_ready = 1'b0;
   logic [15:0] seed0 = '0;
   logic [15:0] seed1 = '0;
   logic        v2, v4, o2, o4;
   logic [31:0] num2;
   logic [63:0] num4;
   logic [15:0] cnt2, cnt4;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fibonacci_multi #(.W(16), .LANES(2), .CW(16)) u2 (
      .clk(clk), .rst(rst), .start(start), .seed0(seed0), .seed1(seed1),
      .out_valid(v2), .out_ready(out_ready), .num(num2), .overflow(o2), .count(cnt2));

   fibonacci_multi #(.W(16), .LANES(4), .CW(16)) u4 (
      .clk(clk), .rst(rst), .start(start), .seed0(seed0), .seed1(seed1),
      .out_valid(v4), .out_ready(out_ready), .num(num4), .overflow(o4), .count(cnt4));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] fib(input logic [15:0] s0, input logic [15:0] s1, input int k);
      int unsigned a, b, c;
      a = s0;
      b = s1;
      if (k == 0) return s0;
      for (int i = 2; i <= k; i++) begin
         c = a + b;
         a = b;
         b = c % 65536;
      end
      return b[15:0];
   endfunction

   // true if any term with index <= k had an exact sum above 16 bits
   function automatic bit ovf_through(input logic [15:0] s0, input logic [15:0] s1, input int k);
      int unsigned a, b, c;
      bit f;
      a = s0;
      b = s1;
      f = 1'b0;
      for (int i = 2; i <= k; i++) begin
         c = a + b;
         if (c > 65535) f = 1'b1;
         a = b;
         b = c % 65536;
      end
      return f;
   endfunction

   int          m_lanes [2] = '{2, 4};
   logic [15:0] m_s0    [2] = '{16'd0, 16'd0};
   logic [15:0] m_s1    [2] = '{16'd0, 16'd0};
   int          m_g     [2] = '{0, 0};
   logic        m_valid [2] = '{1'b0, 1'b0};
   logic        m_ovf   [2] = '{1'b0, 1'b0};
   logic        m_zero  [2] = '{1'b1, 1'b1};
   logic [15:0] m_cnt   [2] = '{16'd0, 16'd0};

   task automatic cmp(input int d, input logic v, input logic [63:0] n, input logic [15:0] c,
                      input logic o);
      logic [63:0] e;
      e = '0;
      chk($sformatf("d%0d out_valid", d), v, m_valid[d]);
      chk($sformatf("d%0d count", d), c, m_cnt[d]);
      chk($sformatf("d%0d overflow", d), o, m_ovf[d]);
      if (m_valid[d] || m_zero[d]) begin
         if (!m_zero[d]) begin
            for (int i = 0; i < m_lanes[d]; i++)
               e[i*16 +: 16] = fib(m_s0[d], m_s1[d], m_g[d] * m_lanes[d] + i);
         end
         chk($sformatf("d%0d num", d), n, e);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst);
         for (int d = 0; d < 2; d++) begin
            if (!rst) begin
               m_valid[d] = 1'b0;
               m_ovf[d]   = 1'b0;
               m_cnt[d]   = '0;
               m_zero[d]  = 1'b1;
               m_g[d]     = 0;
            end else if (start) begin
               m_s0[d]   = seed0;
               m_s1[d]   = seed1;
               m_g[d]    = 0;
               m_cnt[d]  = '0;
               m_zero[d] = 1'b0;
               if (HALT && ovf_through(seed0, seed1, m_lanes[d] - 1)) begin
                  m_valid[d] = 1'b0;
                  m_ovf[d]   = 1'b1;
               end else begin
                  m_valid[d] = 1'b1;
                  m_ovf[d]   = 1'b0;
               end
            end else if (m_valid[d] && out_ready) begin
               m_cnt[d] = m_cnt[d] + 16'd1;
               if (HALT && ovf_through(m_s0[d], m_s1[d], (m_g[d] + 2) * m_lanes[d] - 1)) begin
                  m_valid[d] = 1'b0;
                  m_ovf[d]   = 1'b1;
               end else begin
                  m_g[d] = m_g[d] + 1;
               end
            end
         end
         #1;
         cmp(0, v2, {32'd0, num2}, cnt2, o2);
         cmp(1, v4, num4, cnt4, o4);
      end
   end

   initial begin
      chk("model fib22", fib(16'd1, 16'd1, 22), 64'd28657);
      chk("model fib25", fib(16'd1, 16'd1, 25), 64'd55857);
      chk("model ovf23", ovf_through(16'd1, 16'd1, 23), 64'd0);
      chk("model ovf24", ovf_through(16'd1, 16'd1, 24), 64'd1);

      repeat (3) @(negedge clk);
      rst = 1'b1; out_ready = 1'b1; seed0 = 16'h1234; seed1 = 16'd5;
      repeat (2) @(negedge clk);

      // basic sequence, always ready
      seed0 = 16'd1; seed1 = 16'd1; start = 1'b1; out_ready = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("seq g0", num2, 32'h0001_0001);
      chk("seq c0", cnt2, 16'd0);
      chk("seq l4 g0", num4, 64'h0003_0002_0001_0001);
      @(negedge clk);
      chk("seq g1", num2, 32'h0003_0002);
      chk("seq c1", cnt2, 16'd1);
      @(negedge clk);
      chk("seq g2", num2, 32'h0008_0005);
      @(negedge clk);
      chk("seq g3", num2, 32'h0015_000D);
      chk("seq c3", cnt2, 16'd3);

      // stall while (2,3) is shown
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk); out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("stall hold", num2, 32'h0003_0002);
         chk("stall count", cnt2, 16'd1);
         if (i < 2) @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("stall release", num2, 32'h0008_0005);

      // run up to the first overflowing term
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (11) @(negedge clk);
      chk("g11", num2, 32'hB520_6FF1);
      chk("g11 count", cnt2, 16'd11);
      @(negedge clk);
      chk("g12 count", cnt2, 16'd12);
`ifdef FIB_OVERFLOW_HALT_EN
      chk("halt valid", v2, 64'd0);
      chk("halt overflow", o2, 64'd1);
`else
      chk("wrap g12", num2, 32'hDA31_2511);
      chk("wrap overflow", o2, 64'd0);
`endif
      repeat (3) @(negedge clk);

      // four lanes, restart during a handshake
      seed0 = 16'd2; seed1 = 16'd1; start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("l4 g0", num4, 64'h0004_0003_0001_0002);
      @(negedge clk);
      chk("l4 g1", num4, 64'h001D_0012_000B_0007);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("l4 restart", num4, 64'h0004_0003_0001_0002);
      chk("l4 restart count", cnt4, 16'd0);

      // group 0 overflows on four lanes
      seed0 = 16'hFFFF; seed1 = 16'd2; start = 1'b1;
      @(negedge clk); start = 1'b0;
`ifdef FIB_OVERFLOW_HALT_EN
      chk("start ovf valid", v4, 64'd0);
      chk("start ovf flag", o4, 64'd1);
`else
      chk("start wrap g0", num4, 64'h0003_0001_0002_FFFF);
`endif

      // asynchronous reset mid-run
      seed0 = 16'd1; seed1 = 16'd1; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      #2;
      chk("arst valid", v2, 64'd0);
      chk("arst num", num2, 64'd0);
      chk("arst count", cnt2, 64'd0);
      chk("arst num4", num4, 64'd0);
      @(negedge clk); rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("post rst idle", v2, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1; seed0 = 16'd2; seed1 = 16'd1; start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("start on release", num2, 32'h0001_0002);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         start     = ($urandom_range(0, 30) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1) == 1) begin
            seed0 = 16'($urandom_range(0, 3));
            seed1 = 16'($urandom_range(0, 3));
         end else begin
            seed0 = 16'($urandom);
            seed1 = 16'($urandom);
         end
      end
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
